// File: rtl/subleq_run_ctrl_if.sv
// Purpose : bundles the key, CPU-status and debug signals of the subleq run/step sequencer.
// Latency : n/a (wiring only).
// Backpressure: none; all signals are plain levels or single-cycle pulses.
//
// Ports (slave = sequencer side):
//   iRunKey, iStepKey     asynchronous key levels, active high
//   iLimit                prescaler compare; one enable slot every iLimit+1 cycles
//   iBreakEn, iBreakAddr  instruction-address breakpoint
//   iIP, iPhase           CPU instruction pointer and phase counter
//   oCpuEnable            one-cycle CPU advance pulse
//   oState                0 HALT, 1 RUN, 2 STEP, 3 BREAK
//   oRetired              instructions retired since reset
//   oStopPending          pause requested, waiting for the instruction to finish
interface subleq_run_ctrl_if #(
    parameter int IP_WIDTH    = 13,
    parameter int LIMIT_WIDTH = 8
);
    logic                   iRunKey;
    logic                   iStepKey;
    logic [LIMIT_WIDTH-1:0] iLimit;
    logic                   iBreakEn;
    logic [IP_WIDTH-1:0]    iBreakAddr;
    logic [IP_WIDTH-1:0]    iIP;
    logic [1:0]             iPhase;
    logic                   oCpuEnable;
    logic [1:0]             oState;
    logic [31:0]            oRetired;
    logic                   oStopPending;

    modport slave (
        input  iRunKey, iStepKey, iLimit, iBreakEn, iBreakAddr, iIP, iPhase,
        output oCpuEnable, oState, oRetired, oStopPending
    );

    modport master (
        output iRunKey, iStepKey, iLimit, iBreakEn, iBreakAddr, iIP, iPhase,
        input  oCpuEnable, oState, oRetired, oStopPending
    );
endinterface

// File: rtl/subleq_run_ctrl.sv
// Purpose : run/step/breakpoint sequencer producing the subleq CPU clock-enable.
// Latency : key to state change 3 clocks; oCpuEnable is combinational from state/prescaler.
// Backpressure: none; stops only take effect at instruction boundaries.
//
// Ports:
//   iClock, iReset  clock and synchronous active-high reset
//   bus             subleq_run_ctrl_if.slave (keys, limit, breakpoint, CPU IP/phase in;
//                   enable, state, retired count, stop-pending out)
// RETIRE_PRELOAD is the reset value of the retired counter (0 in normal use).
module subleq_run_ctrl #(
    parameter int          IP_WIDTH       = 13,
    parameter int          PHASES         = 4,
    parameter int          LIMIT_WIDTH    = 8,
    parameter logic [31:0] RETIRE_PRELOAD = 32'd0
) (
    input  logic              iClock,
    input  logic              iReset,
    subleq_run_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;

    localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic                   run_s1, run_s2, run_prev;
    logic                   step_s1, step_s2, step_prev;
    logic                   run_pulse;
    logic                   step_pulse;
    logic [LIMIT_WIDTH-1:0] presc_q;
    logic                   tick;
    logic                   bphit;
    logic                   armed_q;
    logic                   pend_q;
    logic [31:0]            retired_q;
    logic                   cpu_en;
    logic                   retire;
    logic                   enter_run;

    // Key synchronizers; prev flop turns a held level into one pulse.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            run_s1    <= 1'b0;
            run_s2    <= 1'b0;
            run_prev  <= 1'b0;
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            run_s1    <= bus.iRunKey;
            run_s2    <= run_s1;
            run_prev  <= run_s2;
            step_s1   <= bus.iStepKey;
            step_s2   <= step_s1;
            step_prev <= step_s2;
        end
    end

    assign run_pulse  = run_s2 & ~run_prev;
    assign step_pulse = step_s2 & ~step_prev;

    // Free-running prescaler; a count stranded above a lowered limit restarts without a tick.
    assign tick = (presc_q == bus.iLimit);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            presc_q <= '0;
        end else if (presc_q >= bus.iLimit) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // Breakpoint matches only at the start of an instruction.
    assign bphit = bus.iBreakEn & armed_q & (bus.iPhase == 2'd0) & (bus.iIP == bus.iBreakAddr);

    // State register
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= ST_HALT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT, ST_BREAK: begin
                if (run_pulse) begin
                    state_d = ST_RUN;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (bphit & tick) begin
                    state_d = ST_BREAK;
                end else if (retire & (pend_q | run_pulse)) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                if (retire) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Output logic; reset forces the enable low even before the state settles.
    always_comb begin
        cpu_en = 1'b0;
        if (!iReset && tick) begin
            if (state_q == ST_STEP) begin
                cpu_en = 1'b1;
            end else if (state_q == ST_RUN && !bphit) begin
                cpu_en = 1'b1;
            end
        end
    end

    assign retire    = cpu_en & (bus.iPhase == LAST_PHASE);
    assign enter_run = (state_d == ST_RUN) & (state_q != ST_RUN);

    // Clearing armed on entry to RUN lets a resumed breakpoint instruction execute once.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            armed_q   <= 1'b0;
            pend_q    <= 1'b0;
            retired_q <= RETIRE_PRELOAD;
        end else begin
            if (retire) begin
                retired_q <= retired_q + 32'd1;
            end
            if (enter_run) begin
                armed_q <= 1'b0;
            end else if (retire) begin
                armed_q <= 1'b1;
            end
            if (state_q == ST_RUN) begin
                if (retire & (pend_q | run_pulse)) begin
                    pend_q <= 1'b0;
                end else if (run_pulse) begin
                    pend_q <= 1'b1;
                end
            end
        end
    end

    assign bus.oCpuEnable   = cpu_en;
    assign bus.oState       = state_q;
    assign bus.oRetired     = retired_q;
    assign bus.oStopPending = pend_q;
endmodule
